// File: rtl/srm_ctrl_pkg.sv
// Shared definitions for the Simple RISC Machine control FSM.
// Contents:
//   state_t      - FSM state enumeration
//   OPC_* / OP_* - instruction opcode and op field encodings
//   NSEL_*       - one-hot register select codes
//   VSEL_*       - one-hot writeback source codes
//   ctrl_t       - bundle of every registered control output
//   is_mem       - LDR/STR classifier
//   ctrl_decode  - state (plus opcode/op where needed) to control outputs
package srm_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPD,
    S_DEC,
    S_MOVI,
    S_GETA,
    S_GETB,
    S_ALU,
    S_WB,
    S_ADDR,
    S_MRD,
    S_MWB,
    S_GETD,
    S_MWR,
    S_BR,
    S_HALT
  } state_t;

  // Opcode field values
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_B    = 3'b001;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // Op field values
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MEM     = 2'b00;
  localparam logic [1:0] OP_B       = 2'b00;

  // Register select (one-hot)
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  // Writeback source (one-hot)
  localparam logic [3:0] VSEL_MDATA = 4'b1000;
  localparam logic [3:0] VSEL_IMM   = 4'b0100;
  localparam logic [3:0] VSEL_PC    = 4'b0010;
  localparam logic [3:0] VSEL_C     = 4'b0001;

  typedef struct packed {
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
    logic       loadir;
    logic       loadpc;
    logic       incp;
    logic       execb;
    logic       tsel;
    logic       msel;
    logic       mwrite;
    logic       halted;
  } ctrl_t;

  function automatic logic is_mem(input logic [2:0] opcode, input logic [1:0] op);
    return ((opcode == OPC_LDR) || (opcode == OPC_STR)) && (op == OP_MEM);
  endfunction

  // Outputs for a given state. Only ALU looks at the instruction fields,
  // which are stable for the whole instruction.
  function automatic ctrl_t ctrl_decode(input state_t s,
                                        input logic [2:0] opcode,
                                        input logic [1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF1: c.msel = 1'b1;
      S_IF2: begin
        c.msel   = 1'b1;
        c.loadir = 1'b1;
      end
      S_UPD: begin
        c.loadpc = 1'b1;
        c.incp   = 1'b1;
      end
      S_MOVI: begin
        c.nsel  = NSEL_RN;
        c.vsel  = VSEL_IMM;
        c.write = 1'b1;
      end
      S_GETA: begin
        c.nsel  = NSEL_RN;
        c.loada = 1'b1;
      end
      S_GETB: begin
        c.nsel  = NSEL_RM;
        c.loadb = 1'b1;
      end
      S_ALU: begin
        c.loadc = 1'b1;
        // MOV Rd,Rm passes B through the ALU with A forced to zero
        c.asel  = (opcode == OPC_MOV);
        c.loads = (opcode == OPC_ALU) && (op == OP_CMP);
      end
      S_WB: begin
        c.nsel  = NSEL_RD;
        c.vsel  = VSEL_C;
        c.write = 1'b1;
      end
      S_ADDR: begin
        c.bsel  = 1'b1;
        c.loadc = 1'b1;
      end
      S_MWB: begin
        c.nsel  = NSEL_RD;
        c.vsel  = VSEL_MDATA;
        c.write = 1'b1;
      end
      S_GETD: begin
        c.nsel  = NSEL_RD;
        c.loadb = 1'b1;
      end
      S_MWR: c.mwrite = 1'b1;
      S_BR: begin
        c.execb  = 1'b1;
        c.loadpc = 1'b1;
      end
      S_HALT: c.halted = 1'b1;
      default: c = '0;  // RST, DEC, MRD (msel=0 addresses RAM from datapath)
    endcase
    return c;
  endfunction

endpackage

// File: rtl/srm_ctrl_fsm.sv
// Multi-cycle control FSM for the Simple RISC Machine CPU.
// Sequences fetch, PC update, decode, execute, memory access and writeback.
// Moore machine: every output is a register loaded from the decode of the
// next state, so outputs line up with the registered state.
//
// Parameter:
//   MEM_LAT - RAM read wait cycles in IF1 and MRD (legal 1..15)
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   opcode, op          - decoded instruction fields
//   nsel, vsel          - one-hot register select / writeback source
//   loada..loads        - datapath register loads
//   asel, bsel          - operand selects
//   write               - register file write
//   loadir, loadpc      - IR / PC loads
//   incp, execb, tsel   - PC source selects (tsel tied low)
//   msel, mwrite        - RAM address select / write enable
//   halted              - high in HALT
module srm_ctrl_fsm
  import srm_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       loadir,
  output logic       loadpc,
  output logic       incp,
  output logic       execb,
  output logic       tsel,
  output logic       msel,
  output logic       mwrite,
  output logic       halted
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_LAT - 1);

  state_t     state_reg, state_next;
  logic [3:0] wait_reg, wait_next;
  ctrl_t      ctrl_reg;
  logic       wait_done;

  assign wait_done = (wait_reg == WAIT_LAST);

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    case (state_reg)
      S_RST: state_next = S_IF1;
      S_IF1: begin
        wait_next = wait_reg + 4'd1;
        if (wait_done) state_next = S_IF2;
      end
      S_IF2: state_next = S_UPD;
      S_UPD: state_next = S_DEC;
      S_DEC: begin
        if (opcode == OPC_MOV && op == OP_MOV_IMM)      state_next = S_MOVI;
        else if (opcode == OPC_MOV && op == OP_MOV_REG) state_next = S_GETB;
        else if (opcode == OPC_ALU || is_mem(opcode, op)) state_next = S_GETA;
        else if (opcode == OPC_B && op == OP_B)         state_next = S_BR;
        else if (opcode == OPC_HALT)                    state_next = S_HALT;
        else                                            state_next = S_IF1;
      end
      S_MOVI: state_next = S_IF1;
      S_GETA: state_next = is_mem(opcode, op) ? S_ADDR : S_GETB;
      S_GETB: state_next = S_ALU;
      S_ALU:  state_next = (opcode == OPC_ALU && op == OP_CMP) ? S_IF1 : S_WB;
      S_WB:   state_next = S_IF1;
      S_ADDR: state_next = (opcode == OPC_LDR) ? S_MRD : S_GETD;
      S_MRD: begin
        wait_next = wait_reg + 4'd1;
        if (wait_done) state_next = S_MWB;
      end
      S_MWB:  state_next = S_IF1;
      S_GETD: state_next = S_MWR;
      S_MWR:  state_next = S_IF1;
      S_BR:   state_next = S_IF1;
      S_HALT: state_next = S_HALT;
      default: state_next = S_RST;
    endcase
    // Any entry into a waiting state restarts the count
    if ((state_next == S_IF1 || state_next == S_MRD) && (state_next != state_reg))
      wait_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_RST;
      wait_reg  <= '0;
      ctrl_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      ctrl_reg  <= ctrl_decode(state_next, opcode, op);
    end
  end

  assign nsel   = ctrl_reg.nsel;
  assign vsel   = ctrl_reg.vsel;
  assign loada  = ctrl_reg.loada;
  assign loadb  = ctrl_reg.loadb;
  assign loadc  = ctrl_reg.loadc;
  assign loads  = ctrl_reg.loads;
  assign asel   = ctrl_reg.asel;
  assign bsel   = ctrl_reg.bsel;
  assign write  = ctrl_reg.write;
  assign loadir = ctrl_reg.loadir;
  assign loadpc = ctrl_reg.loadpc;
  assign incp   = ctrl_reg.incp;
  assign execb  = ctrl_reg.execb;
  assign tsel   = ctrl_reg.tsel;
  assign msel   = ctrl_reg.msel;
  assign mwrite = ctrl_reg.mwrite;
  assign halted = ctrl_reg.halted;

endmodule

// File: tb/tb_srm_ctrl_fsm.sv
// Testbench for srm_ctrl_fsm. Two instances (MEM_LAT=1 and MEM_LAT=3) with
// independent inputs; outputs are packed into a 22-bit observation word.
module tb_srm_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v [2];
  logic [2:0] opc_v [2];
  logic [1:0] op_v  [2];
  wire  [21:0] obs0, obs1;

  // Observation word bit layout
  localparam logic [21:0] O_HALTED = 22'd1 << 0;
  localparam logic [21:0] O_MWRITE = 22'd1 << 1;
  localparam logic [21:0] O_MSEL   = 22'd1 << 2;
  localparam logic [21:0] O_EXECB  = 22'd1 << 4;
  localparam logic [21:0] O_INCP   = 22'd1 << 5;
  localparam logic [21:0] O_LOADPC = 22'd1 << 6;
  localparam logic [21:0] O_LOADIR = 22'd1 << 7;
  localparam logic [21:0] O_WRITE  = 22'd1 << 8;
  localparam logic [21:0] O_BSEL   = 22'd1 << 9;
  localparam logic [21:0] O_ASEL   = 22'd1 << 10;
  localparam logic [21:0] O_LOADS  = 22'd1 << 11;
  localparam logic [21:0] O_LOADC  = 22'd1 << 12;
  localparam logic [21:0] O_LOADB  = 22'd1 << 13;
  localparam logic [21:0] O_LOADA  = 22'd1 << 14;
  localparam logic [21:0] V_C      = 22'd1 << 15;
  localparam logic [21:0] V_IMM    = 22'd4 << 15;
  localparam logic [21:0] V_MDATA  = 22'd8 << 15;
  localparam logic [21:0] N_RM     = 22'd1 << 19;
  localparam logic [21:0] N_RD     = 22'd2 << 19;
  localparam logic [21:0] N_RN     = 22'd4 << 19;

  srm_ctrl_fsm #(.MEM_LAT(1)) dut0 (
    .clk(clk), .rst(rst_v[0]), .opcode(opc_v[0]), .op(op_v[0]),
    .nsel(obs0[21:19]), .vsel(obs0[18:15]), .loada(obs0[14]), .loadb(obs0[13]),
    .loadc(obs0[12]), .loads(obs0[11]), .asel(obs0[10]), .bsel(obs0[9]),
    .write(obs0[8]), .loadir(obs0[7]), .loadpc(obs0[6]), .incp(obs0[5]),
    .execb(obs0[4]), .tsel(obs0[3]), .msel(obs0[2]), .mwrite(obs0[1]),
    .halted(obs0[0])
  );

  srm_ctrl_fsm #(.MEM_LAT(3)) dut1 (
    .clk(clk), .rst(rst_v[1]), .opcode(opc_v[1]), .op(op_v[1]),
    .nsel(obs1[21:19]), .vsel(obs1[18:15]), .loada(obs1[14]), .loadb(obs1[13]),
    .loadc(obs1[12]), .loads(obs1[11]), .asel(obs1[10]), .bsel(obs1[9]),
    .write(obs1[8]), .loadir(obs1[7]), .loadpc(obs1[6]), .incp(obs1[5]),
    .execb(obs1[4]), .tsel(obs1[3]), .msel(obs1[2]), .mwrite(obs1[1]),
    .halted(obs1[0])
  );

  int tests = 0;
  int fails = 0;
  logic [21:0] exp_q[$];

  typedef struct {
    logic [2:0] opc;
    logic [1:0] op;
    int d;
    int cyc;
    int wr;
    int ld;
    int mw;
  } vec_t;
  localparam int NV = 17;
  vec_t tbl[NV];

  function automatic logic [21:0] get_obs(input int d);
    return (d == 0) ? obs0 : obs1;
  endfunction

  // Instruction-level reference: expected output word per cycle, starting at
  // the first fetch cycle and ending just before the next fetch.
  function automatic void build_trace(input int lat, input logic [2:0] opc,
                                      input logic [1:0] op, input int halt_cycles);
    exp_q.delete();
    for (int i = 0; i < lat; i++) exp_q.push_back(O_MSEL);
    exp_q.push_back(O_MSEL | O_LOADIR);
    exp_q.push_back(O_LOADPC | O_INCP);
    exp_q.push_back('0);
    if (opc == 3'b110 && op == 2'b10) begin
      exp_q.push_back(N_RN | V_IMM | O_WRITE);
    end else if (opc == 3'b110 && op == 2'b00) begin
      exp_q.push_back(N_RM | O_LOADB);
      exp_q.push_back(O_LOADC | O_ASEL);
      exp_q.push_back(N_RD | V_C | O_WRITE);
    end else if (opc == 3'b101) begin
      exp_q.push_back(N_RN | O_LOADA);
      exp_q.push_back(N_RM | O_LOADB);
      exp_q.push_back(O_LOADC | ((op == 2'b01) ? O_LOADS : 22'd0));
      if (op != 2'b01) exp_q.push_back(N_RD | V_C | O_WRITE);
    end else if (opc == 3'b011 && op == 2'b00) begin
      exp_q.push_back(N_RN | O_LOADA);
      exp_q.push_back(O_BSEL | O_LOADC);
      for (int i = 0; i < lat; i++) exp_q.push_back('0);
      exp_q.push_back(N_RD | V_MDATA | O_WRITE);
    end else if (opc == 3'b100 && op == 2'b00) begin
      exp_q.push_back(N_RN | O_LOADA);
      exp_q.push_back(O_BSEL | O_LOADC);
      exp_q.push_back(N_RD | O_LOADB);
      exp_q.push_back(O_MWRITE);
    end else if (opc == 3'b001 && op == 2'b00) begin
      exp_q.push_back(O_EXECB | O_LOADPC);
    end else if (opc == 3'b111) begin
      for (int i = 0; i < halt_cycles; i++) exp_q.push_back(O_HALTED);
    end
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    rst_v[d] = 1'b1;
    step();
    check($sformatf("reset_c1_d%0d", d), get_obs(d), '0);
    step();
    check($sformatf("reset_c2_d%0d", d), get_obs(d), '0);
    rst_v[d] = 1'b0;
    step();
    check($sformatf("reset_if1_d%0d", d), get_obs(d), O_MSEL);
  endtask

  // Starts on the first fetch cycle; returns with the DUT on the next
  // instruction's first fetch cycle (cyc = cycles used, -1 if no next fetch
  // occurs within max_cyc).
  task automatic run_instr(input int d, input int lat, input logic [2:0] opc,
                           input logic [1:0] op, input int max_cyc,
                           output int cyc, output int wr, output int ld, output int mw);
    logic [21:0] o;
    logic seen_upd;
    opc_v[d] = opc;
    op_v[d]  = op;
    build_trace(lat, opc, op, max_cyc);
    cyc = -1; wr = 0; ld = 0; mw = 0; seen_upd = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      o = get_obs(d);
      if (seen_upd && o[2]) begin
        cyc = k;
        break;
      end
      if (k < exp_q.size()) begin
        check($sformatf("trace d%0d %b_%b c%0d", d, opc, op, k), o, exp_q[k]);
      end else begin
        tests++;
        fails++;
        $display("FAIL overrun d%0d %b_%b c%0d: got %06h required end of instruction",
                 d, opc, op, k, o);
      end
      if (o[5]) seen_upd = 1'b1;
      if (o[8]) wr++;
      if (o[11]) ld++;
      if (o[1]) mw++;
      step();
    end
    $display("[TB] d%0d %b_%b cycles=%0d writes=%0d loads=%0d mwrite=%0d",
             d, opc, op, cyc, wr, ld, mw);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, wr, ld, mw;
    logic [2:0] ro;
    logic [1:0] rp;
    bit found;

    tbl[0]  = '{3'b110, 2'b10, 0, 5, 1, 0, 0};  // MOV R0,#7
    tbl[1]  = '{3'b110, 2'b00, 0, 7, 1, 0, 0};  // MOV Rd,Rm
    tbl[2]  = '{3'b101, 2'b00, 0, 8, 1, 0, 0};  // ADD
    tbl[3]  = '{3'b101, 2'b01, 0, 7, 0, 1, 0};  // CMP
    tbl[4]  = '{3'b101, 2'b10, 0, 8, 1, 0, 0};  // AND
    tbl[5]  = '{3'b101, 2'b11, 0, 8, 1, 0, 0};  // MVN
    tbl[6]  = '{3'b011, 2'b00, 0, 8, 1, 0, 0};  // LDR
    tbl[7]  = '{3'b100, 2'b00, 0, 8, 0, 0, 1};  // STR
    tbl[8]  = '{3'b001, 2'b00, 0, 5, 0, 0, 0};  // B
    tbl[9]  = '{3'b000, 2'b00, 0, 4, 0, 0, 0};  // NOP encodings
    tbl[10] = '{3'b001, 2'b01, 0, 4, 0, 0, 0};
    tbl[11] = '{3'b011, 2'b01, 0, 4, 0, 0, 0};
    tbl[12] = '{3'b110, 2'b11, 0, 4, 0, 0, 0};
    tbl[13] = '{3'b011, 2'b00, 1, 12, 1, 0, 0}; // LDR, MEM_LAT=3
    tbl[14] = '{3'b110, 2'b10, 1, 7, 1, 0, 0};
    tbl[15] = '{3'b100, 2'b00, 1, 10, 0, 0, 1};
    tbl[16] = '{3'b101, 2'b01, 1, 9, 0, 1, 0};

    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    opc_v[0] = '0; opc_v[1] = '0; op_v[0] = '0; op_v[1] = '0;

    // Reset in the middle of a store's write cycle
    do_reset(0);
    opc_v[0] = 3'b100; op_v[0] = 2'b00;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (obs0[1]) begin
        found = 1'b1;
        break;
      end
      step();
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL str_reach_mwr: got no mwrite required mwrite within 40 cycles");
    end
    check("mwr_single_strobe", obs0, O_MWRITE);
    do_reset(0);

    // Table-driven instructions
    for (int i = 0; i < NV; i++) begin
      if (i == 0 || tbl[i].d != tbl[i-1].d) do_reset(tbl[i].d);
      run_instr(tbl[i].d, (tbl[i].d == 0) ? 1 : 3, tbl[i].opc, tbl[i].op, 40,
                cyc, wr, ld, mw);
      check_int($sformatf("cycles_%0d", i), cyc, tbl[i].cyc);
      check_int($sformatf("writes_%0d", i), wr, tbl[i].wr);
      check_int($sformatf("loads_%0d", i), ld, tbl[i].ld);
      check_int($sformatf("mwrite_%0d", i), mw, tbl[i].mw);
    end

    // HALT holds for 20 cycles after fetch, then reset recovers
    do_reset(0);
    run_instr(0, 1, 3'b111, 2'b00, 24, cyc, wr, ld, mw);
    check_int("halt_no_exit", cyc, -1);
    do_reset(0);
    do_reset(1);
    run_instr(1, 3, 3'b111, 2'b11, 16, cyc, wr, ld, mw);
    check_int("halt_no_exit_lat3", cyc, -1);

    // Random instruction streams against the reference model
    do_reset(0);
    for (int n = 0; n < 60; n++) begin
      ro = 3'($urandom_range(0, 6));
      rp = 2'($urandom_range(0, 3));
      run_instr(0, 1, ro, rp, 40, cyc, wr, ld, mw);
      check_int($sformatf("rand_len_d0_%0d", n), cyc, exp_q.size());
    end
    do_reset(1);
    for (int n = 0; n < 25; n++) begin
      ro = 3'($urandom_range(0, 6));
      rp = 2'($urandom_range(0, 3));
      run_instr(1, 3, ro, rp, 40, cyc, wr, ld, mw);
      check_int($sformatf("rand_len_d1_%0d", n), cyc, exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
